// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch resolver with a valid/ready handshake.
// It resolves six signed and four unsigned branch conditions and returns next_pc,
// taken and mispredict one cycle after a request is accepted.
// Optional macro BRANCH_PREDICT_EN builds a per-PC 2-bit saturating predictor.
// Without the macro the prediction is static not-taken.
module branch_resolve_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ID_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    pc_in,
  input  logic [ID_WIDTH-1:0] instr_id,
  input  logic [WIDTH-1:0]    rs,
  input  logic [WIDTH-1:0]    rt,
  input  logic [WIDTH-1:0]    rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    next_pc,
  output logic                taken,
  output logic                is_branch,
  output logic                pred_taken,
  output logic                mispredict
);

  logic             accept;
  logic             br_c;
  logic             cond_c;
  logic             pred_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] npc_c;

  // Single output stage: a new request is accepted whenever the held result leaves or is absent.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode the branch code and evaluate its condition.
  always_comb begin
    br_c   = 1'b1;
    cond_c = 1'b0;
    case (instr_id)
      ID_WIDTH'(15): cond_c = (rs == rt);
      ID_WIDTH'(16): cond_c = (rs != rt);
      ID_WIDTH'(17): cond_c = ($signed(rs) >  $signed(rt));
      ID_WIDTH'(18): cond_c = ($signed(rs) >= $signed(rt));
      ID_WIDTH'(19): cond_c = ($signed(rs) <  $signed(rt));
      ID_WIDTH'(20): cond_c = ($signed(rs) <= $signed(rt));
      ID_WIDTH'(21): cond_c = (rs >  rt);
      ID_WIDTH'(22): cond_c = (rs >= rt);
      ID_WIDTH'(23): cond_c = (rs <  rt);
      ID_WIDTH'(24): cond_c = (rs <= rt);
      default:       br_c   = 1'b0;
    endcase
  end

  // Target wraps modulo 2^WIDTH; non-taken or non-branch falls through to pc_in.
  assign target_c = pc_in + rd;
  assign npc_c    = cond_c ? target_c : pc_in;

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] idx;

  assign idx    = pc_in[IDX_W-1:0];
  assign pred_c = br_c && ctr[idx][1];

  // Saturating counter update on every accepted branch; reset returns all entries to weakly not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (accept && br_c) begin
      if (cond_c && (ctr[idx] != 2'b11)) begin
        ctr[idx] <= ctr[idx] + 2'b01;
      end else if (!cond_c && (ctr[idx] != 2'b00)) begin
        ctr[idx] <= ctr[idx] - 2'b01;
      end
    end
  end
`else
  assign pred_c = 1'b0;
`endif

  // Result register: loads on accept, drains on out_ready, holds under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      next_pc    <= '0;
      taken      <= 1'b0;
      is_branch  <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      next_pc    <= npc_c;
      taken      <= cond_c;
      is_branch  <= br_c;
      pred_taken <= pred_c;
      mispredict <= br_c && (pred_c != cond_c);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (WIDTH=32, DEPTH=16, ID_WIDTH=32).
// A behavioural model tracks the output slot and the predictor counters.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_id;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] next_pc;
  logic        taken;
  logic        is_branch;
  logic        pred_taken;
  logic        mispredict;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit          m_valid;
  logic [31:0] m_npc;
  bit          m_taken, m_br, m_pred, m_mis;
  int          cnt [16];

  branch_resolve_unit #(.WIDTH(32), .DEPTH(16), .ID_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_id(instr_id), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc),
    .taken(taken), .is_branch(is_branch), .pred_taken(pred_taken),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition from the instruction table, in plain integer arithmetic.
  function automatic void resolve(input logic [31:0] id, input logic [31:0] a,
                                  input logic [31:0] b, output bit br, output bit tk);
    int          sa, sb;
    longint unsigned ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    br = (id >= 15) && (id <= 24);
    tk = 0;
    if (br) begin
      if      (id == 15) tk = (sa == sb);
      else if (id == 16) tk = (sa != sb);
      else if (id == 17) tk = (sa >  sb);
      else if (id == 18) tk = (sa >= sb);
      else if (id == 19) tk = (sa <  sb);
      else if (id == 20) tk = (sa <= sb);
      else if (id == 21) tk = (ua >  ub);
      else if (id == 22) tk = (ua >= ub);
      else if (id == 23) tk = (ua <  ub);
      else               tk = (ua <= ub);
    end
  endfunction

  task automatic model_reset();
    m_valid = 0; m_npc = 0; m_taken = 0; m_br = 0; m_pred = 0; m_mis = 0;
    for (int i = 0; i < 16; i++) cnt[i] = 1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] off,
                       input bit ordy);
    in_valid = v; pc_in = pc; instr_id = id; rs = a; rt = b; rd = off; out_ready = ordy;
  endtask

  // One clock: check handshake, advance the model on the edge, then check every output.
  task automatic cycle();
    bit acc, br, tk, pr;
    int ix;
    logic [31:0] npc;
    @(negedge clk);
    check("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    acc = in_valid && (!m_valid || out_ready);
    resolve(instr_id, rs, rt, br, tk);
    ix  = int'(pc_in[3:0]);
    npc = tk ? (pc_in + rd) : pc_in;
`ifdef BRANCH_PREDICT_EN
    pr = br && (cnt[ix] >= 2);
`else
    pr = 0;
`endif
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1; m_npc = npc; m_taken = tk; m_br = br; m_pred = pr;
      m_mis = br && (pr != tk);
      if (br) cnt[ix] = tk ? ((cnt[ix] < 3) ? cnt[ix] + 1 : 3) : ((cnt[ix] > 0) ? cnt[ix] - 1 : 0);
    end else if (out_ready) begin
      m_valid = 0;
    end
    check("out_valid",  {63'd0, out_valid},  {63'd0, m_valid});
    check("next_pc",    {32'd0, next_pc},    {32'd0, m_npc});
    check("taken",      {63'd0, taken},      {63'd0, m_taken});
    check("is_branch",  {63'd0, is_branch},  {63'd0, m_br});
    check("pred_taken", {63'd0, pred_taken}, {63'd0, m_pred});
    check("mispredict", {63'd0, mispredict}, {63'd0, m_mis});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd7;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_next_pc",   {32'd0, next_pc},   64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_mispredict",{63'd0, mispredict},64'd0);
    #2 reset = 1'b0;

    // Signed versus unsigned compare on the same operands
    drive(1, 100, 17, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 1); cycle();
    check("bgt_taken",  {63'd0, taken}, 64'd0);
    check("bgt_npc",    {32'd0, next_pc}, 64'd100);
    drive(1, 100, 21, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 1); cycle();
    check("bgtu_taken", {63'd0, taken}, 64'd1);
    check("bgtu_npc",   {32'd0, next_pc}, 64'd96);

    // PC wrap
    drive(1, 32'hFFFF_FFFE, 15, 7, 7, 4, 1); cycle();
    check("wrap_npc", {32'd0, next_pc}, 64'd2);

    // Backpressure: hold a bne result for 3 cycles while a new request waits
    drive(1, 200, 16, 1, 2, 8, 1); cycle();
    check("bne_npc", {32'd0, next_pc}, 64'd208);
    drive(1, 300, 15, 3, 3, 16, 0);
    repeat (3) begin
      cycle();
      check("bp_hold_npc", {32'd0, next_pc}, 64'd208);
    end
    drive(1, 300, 15, 3, 3, 16, 1); cycle();
    check("bp_new_npc", {32'd0, next_pc}, 64'd316);
    drive(0, 0, 0, 0, 0, 0, 1); cycle();

    // Asynchronous reset mid-cycle with a held result
    drive(1, 40, 15, 1, 1, 4, 0); cycle();
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_next_pc",   {32'd0, next_pc},   64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    model_reset();
    #2 reset = 1'b0;

    // Predictor training at pc 5: three taken then one not-taken
    drive(1, 5, 15, 9, 9, 12, 1); cycle();
    check("pred_0", {63'd0, pred_taken}, 64'd0);
    check("mis_0",  {63'd0, mispredict}, 64'd1);
    cycle();
`ifdef BRANCH_PREDICT_EN
    check("pred_1", {63'd0, pred_taken}, 64'd1);
    check("mis_1",  {63'd0, mispredict}, 64'd0);
`else
    check("pred_1", {63'd0, pred_taken}, 64'd0);
    check("mis_1",  {63'd0, mispredict}, 64'd1);
`endif
    cycle();
    drive(1, 5, 15, 9, 8, 12, 1); cycle();
`ifdef BRANCH_PREDICT_EN
    check("pred_nt", {63'd0, pred_taken}, 64'd1);
    check("mis_nt",  {63'd0, mispredict}, 64'd1);
`else
    check("pred_nt", {63'd0, pred_taken}, 64'd0);
    check("mis_nt",  {63'd0, mispredict}, 64'd0);
`endif

    // Non-branch leaves the entry alone; the following branch at pc 5 shows it
    drive(1, 5, 3, 9, 9, 12, 1); cycle();
    check("nb_is_branch", {63'd0, is_branch}, 64'd0);
    check("nb_npc",       {32'd0, next_pc},   64'd5);
    drive(1, 5, 15, 9, 9, 12, 1); cycle();

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40), $urandom_range(0, 30),
            pick_operand(), pick_operand(), $urandom, $urandom_range(0, 2) != 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
